bottleneck_split: RTL

BOTTLENECK_SPLIT -- requirements
Module: bottleneck_split

---
 rtl/bottleneck_pkg.sv | 23 ++
 rtl/bottleneck_ext.sv | 28 ++
 rtl/bottleneck_split.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bottleneck_pkg.sv
// ============================================================
// bottleneck_pkg : shared sizes, FSM states and widths for bottleneck_split
// Revision: 1.0
// ============================================================
`default_nettype none

package bottleneck_pkg;

  localparam int DW = 64;
  localparam int AW = 64;

  localparam logic [1:0] SIZ_BYTE  = 2'd0;
  localparam logic [1:0] SIZ_HALF  = 2'd1;
  localparam logic [1:0] SIZ_WORD  = 2'd2;
  localparam logic [1:0] SIZ_DWORD = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/bottleneck_ext.sv
// ============================================================
// bottleneck_ext : 64-bit sign/zero extension by access size
// Revision: 1.0
// ============================================================
`default_nettype none

module bottleneck_ext
  import bottleneck_pkg::*;
(
  input  logic [DW-1:0] data,
  input  logic [1:0]    siz,
  input  logic          is_signed,
  output logic [DW-1:0] ext
);

  always_comb begin
    ext = data;
    case (siz)
      SIZ_BYTE: ext = {{56{is_signed & data[7]}},  data[7:0]};
      SIZ_HALF: ext = {{48{is_signed & data[15]}}, data[15:0]};
      SIZ_WORD: ext = {{32{is_signed & data[31]}}, data[31:0]};
      default:  ext = data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bottleneck_split.sv
// ============================================================
// bottleneck_split : splits 64-bit master accesses into SDW-bit slave beats
// Revision: 1.0
// ============================================================
`default_nettype none

module bottleneck_split
  import bottleneck_pkg::*;
#(
  parameter int SDW = 16
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic [AW-1:0]  m_adr_i,
  input  logic           m_cyc_i,
  input  logic [DW-1:0]  m_dat_i,
  input  logic           m_signed_i,
  input  logic [1:0]     m_siz_i,
  input  logic           m_stb_i,
  input  logic           m_we_i,
  output logic           m_ack_o,
  output logic [DW-1:0]  m_dat_o,
  output logic [AW-1:0]  s_adr_o,
  output logic           s_cyc_o,
  output logic           s_signed_o,
  output logic [1:0]     s_siz_o,
  output logic           s_stb_o,
  output logic           s_we_o,
  output logic [SDW-1:0] s_dat_o,
  input  logic           s_ack_i,
  input  logic [SDW-1:0] s_dat_i
);

  localparam int SBYTES  = SDW / 8;
  localparam int SMAXSIZ = $clog2(SBYTES);
  localparam int BW      = $clog2(DW / SDW);
  localparam logic [1:0] SMAX = 2'(SMAXSIZ);

  logic [1:0]    state;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat;
  logic [DW-1:0] acc;
  logic [DW-1:0] ext;
  logic [1:0]    siz;
  logic          sgn;
  logic          we;
  logic [BW-1:0] beat;
  logic [BW-1:0] last_beat;
  logic          split;
  logic          in_bus;
  logic          in_done;

  assign split = (siz > SMAX);

  // Beats needed minus one: 2^(siz-SMAXSIZ)-1 for wide accesses, else a single beat.
  always_comb begin
    last_beat = '0;
    if (split)
      last_beat = BW'((32'd1 << (siz - SMAX)) - 32'd1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= ST_IDLE;
      adr   <= '0;
      dat   <= '0;
      acc   <= '0;
      siz   <= '0;
      sgn   <= 1'b0;
      we    <= 1'b0;
      beat  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m_cyc_i && m_stb_i) begin
            adr   <= m_adr_i;
            dat   <= m_dat_i;
            siz   <= m_siz_i;
            sgn   <= m_signed_i;
            we    <= m_we_i;
            beat  <= '0;
            acc   <= '0;
            state <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (!m_cyc_i) begin
            state <= ST_IDLE;
          end else if (s_ack_i) begin
            acc[int'(beat)*SDW +: SDW] <= s_dat_i;
            if (beat == last_beat)
              state <= ST_DONE;
            else
              beat <= beat + BW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_bus  = (state == ST_BUS);
  assign in_done = (state == ST_DONE);

  // Slave side is decoded purely from state and latched request fields.
  assign s_cyc_o    = in_bus;
  assign s_stb_o    = in_bus;
  assign s_adr_o    = in_bus ? (adr + AW'(int'(beat) * SBYTES)) : '0;
  assign s_dat_o    = in_bus ? dat[int'(beat)*SDW +: SDW] : '0;
  assign s_siz_o    = in_bus ? (split ? SMAX : siz) : '0;
  assign s_we_o     = in_bus & we;
  assign s_signed_o = sgn;

  assign m_ack_o = in_done & m_cyc_i;
  assign m_dat_o = (in_done && !we) ? ext : '0;

  bottleneck_ext u_ext (
    .data      (acc),
    .siz       (siz),
    .is_signed (sgn),
    .ext       (ext)
  );

endmodule

`default_nettype wire
